// File: rtl/dds_pulse_meter.sv
// dds_pulse_meter: averaged period, ref-to-input phase lag and loss-of-signal
// detection for DDS pulse trains. Both pulse inputs are synchronized internally.
module dds_pulse_meter #(
    parameter int WIDTH    = 32,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pulse_in,
    input  logic             pulse_ref,
    output logic [WIDTH-1:0] period_out,
    output logic             period_valid,
    output logic [WIDTH-1:0] phase_out,
    output logic             phase_valid,
    output logic             timeout
);

    localparam int SUM_W = WIDTH + AVG_LOG2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [WIDTH-1:0]    TIMEOUT_W = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0]    CNT_ONE   = WIDTH'(1);
    localparam logic [AVG_LOG2:0]   NPER_ONE  = (AVG_LOG2 + 1)'(1);
    localparam logic [AVG_LOG2:0]   NPER_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

    logic [0:0]        state_q,        state_d;
    logic [2:0]        in_sync_q,      in_sync_d;
    logic [2:0]        ref_sync_q,     ref_sync_d;
    logic [WIDTH-1:0]  pcnt_q,         pcnt_d;
    logic [AVG_LOG2:0] nper_q,         nper_d;
    logic [SUM_W-1:0]  sum_q,          sum_d;
    logic [WIDTH-1:0]  period_out_q,   period_out_d;
    logic              period_valid_q, period_valid_d;
    logic [WIDTH-1:0]  phcnt_q,        phcnt_d;
    logic              armed_q,        armed_d;
    logic [WIDTH-1:0]  phase_out_q,    phase_out_d;
    logic              phase_valid_q,  phase_valid_d;
    logic              timeout_q,      timeout_d;

    logic              in_edge;
    logic              ref_edge;
    logic [SUM_W-1:0]  win_total;

    // Same three-flop path on both inputs keeps their relative timing exact.
    assign in_edge   = in_sync_q[1]  & ~in_sync_q[2];
    assign ref_edge  = ref_sync_q[1] & ~ref_sync_q[2];
    assign win_total = sum_q + SUM_W'(pcnt_q);

    always_comb begin
        state_d        = state_q;
        in_sync_d      = {in_sync_q[1:0], pulse_in};
        ref_sync_d     = {ref_sync_q[1:0], pulse_ref};
        pcnt_d         = pcnt_q;
        nper_d         = nper_q;
        sum_d          = sum_q;
        period_out_d   = period_out_q;
        period_valid_d = 1'b0;
        phcnt_d        = phcnt_q;
        armed_d        = armed_q;
        phase_out_d    = phase_out_q;
        phase_valid_d  = 1'b0;
        timeout_d      = timeout_q;

        if (!enable) begin
            state_d = ST_IDLE;
            pcnt_d  = '0;
            nper_d  = '0;
            sum_d   = '0;
            phcnt_d = '0;
            armed_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pcnt_d = '0;
                    nper_d = '0;
                    sum_d  = '0;
                    // The edge leaving IDLE only opens the first period.
                    if (in_edge) begin
                        pcnt_d    = CNT_ONE;
                        state_d   = ST_RUN;
                        timeout_d = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (in_edge) begin
                        pcnt_d = CNT_ONE;
                        if (nper_q == NPER_LAST) begin
                            period_out_d   = WIDTH'(win_total >> AVG_LOG2);
                            period_valid_d = 1'b1;
                            sum_d          = '0;
                            nper_d         = '0;
                        end else begin
                            sum_d  = win_total;
                            nper_d = nper_q + NPER_ONE;
                        end
                    end else if (pcnt_q == TIMEOUT_W) begin
                        state_d      = ST_IDLE;
                        timeout_d    = 1'b1;
                        period_out_d = '0;
                        pcnt_d       = '0;
                        nper_d       = '0;
                        sum_d        = '0;
                    end else begin
                        pcnt_d = pcnt_q + CNT_ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (ref_edge && in_edge) begin
                phase_out_d   = '0;
                phase_valid_d = 1'b1;
                armed_d       = 1'b0;
            end else if (ref_edge) begin
                phcnt_d = '0;
                armed_d = 1'b1;
            end else if (armed_q) begin
                if (in_edge) begin
                    phase_out_d   = phcnt_q;
                    phase_valid_d = 1'b1;
                    armed_d       = 1'b0;
                end else if (phcnt_q != '1) begin
                    phcnt_d = phcnt_q + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            in_sync_q      <= '0;
            ref_sync_q     <= '0;
            pcnt_q         <= '0;
            nper_q         <= '0;
            sum_q          <= '0;
            period_out_q   <= '0;
            period_valid_q <= 1'b0;
            phcnt_q        <= '0;
            armed_q        <= 1'b0;
            phase_out_q    <= '0;
            phase_valid_q  <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            in_sync_q      <= in_sync_d;
            ref_sync_q     <= ref_sync_d;
            pcnt_q         <= pcnt_d;
            nper_q         <= nper_d;
            sum_q          <= sum_d;
            period_out_q   <= period_out_d;
            period_valid_q <= period_valid_d;
            phcnt_q        <= phcnt_d;
            armed_q        <= armed_d;
            phase_out_q    <= phase_out_d;
            phase_valid_q  <= phase_valid_d;
            timeout_q      <= timeout_d;
        end
    end

    assign period_out   = period_out_q;
    assign period_valid = period_valid_q;
    assign phase_out    = phase_out_q;
    assign phase_valid  = phase_valid_q;
    assign timeout      = timeout_q;

endmodule
